// File: rtl/activity_trig_ctrl_if.sv
// rtl/activity_trig_ctrl_if.sv - start/abort, configuration and status bundle of the burst sequencer
interface activity_trig_ctrl_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8,
    parameter int DIV_W   = 4
) ();
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   cfg_delay;
    logic [CNT_W-1:0]   cfg_on;
    logic [CNT_W-1:0]   cfg_off;
    logic [BURST_W-1:0] cfg_bursts;
    logic [DIV_W-1:0]   cfg_div;
    logic               activity_trig;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] burst_idx;

    modport master (
        output start, abort, cfg_delay, cfg_on, cfg_off, cfg_bursts, cfg_div,
        input  activity_trig, busy, done, burst_idx
    );

    modport slave (
        input  start, abort, cfg_delay, cfg_on, cfg_off, cfg_bursts, cfg_div,
        output activity_trig, busy, done, burst_idx
    );
endinterface

// File: rtl/activity_trig_ctrl.sv
// rtl/activity_trig_ctrl.sv - burst sequencer driving activity_trig of the inverter-chain activity generator
module activity_trig_ctrl #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8,
    parameter int DIV_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    activity_trig_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [DIV_W-1:0]   DIV_ONE   = 1;
    localparam logic [BURST_W-1:0] BURST_ONE = 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DIV_W-1:0]   div_cnt, div_cnt_n;
    logic [BURST_W-1:0] idx, idx_n;
    logic               trig, trig_n;
    logic               busy, busy_n;
    logic               done, done_n;

    logic [CNT_W-1:0]   on_q;
    logic [CNT_W-1:0]   off_q;
    logic [BURST_W-1:0] bursts_q;
    logic [DIV_W-1:0]   div_q;

    logic [CNT_W-1:0]   cur_on;
    logic [CNT_W-1:0]   on_ld;

    // Counters load length-1 and run down to 0, so the all-ones length never wraps.
    // A zero-length ON window still occupies one cycle.
    assign cur_on = (state == S_IDLE) ? bus.cfg_on : on_q;
    assign on_ld  = (cur_on == '0) ? '0 : cur_on - CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            div_cnt  <= '0;
            idx      <= '0;
            trig     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            on_q     <= '0;
            off_q    <= '0;
            bursts_q <= '0;
            div_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_cnt <= div_cnt_n;
            idx     <= idx_n;
            trig    <= trig_n;
            busy    <= busy_n;
            done    <= done_n;
            if (state == S_IDLE && bus.start) begin
                on_q     <= bus.cfg_on;
                off_q    <= bus.cfg_off;
                bursts_q <= bus.cfg_bursts;
                div_q    <= bus.cfg_div;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_cnt_n = div_cnt;
        idx_n     = idx;
        trig_n    = trig;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_bursts == '0) begin
                        state_n = S_DONE;
                    end else if (bus.cfg_delay == '0) begin
                        state_n   = S_ON;
                        cnt_n     = on_ld;
                        div_cnt_n = '0;
                    end else begin
                        state_n = S_DELAY;
                        cnt_n   = bus.cfg_delay - CNT_ONE;
                    end
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_n   = S_ON;
                    cnt_n     = on_ld;
                    div_cnt_n = '0;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_ON: begin
                if (cnt == '0) begin
                    // Window exit always parks the trigger low, whatever the toggle parity.
                    trig_n    = 1'b0;
                    div_cnt_n = '0;
                    if (idx == bursts_q - BURST_ONE) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else if (off_q == '0) begin
                        state_n = S_ON;
                        idx_n   = idx + BURST_ONE;
                        cnt_n   = on_ld;
                    end else begin
                        state_n = S_OFF;
                        cnt_n   = off_q - CNT_ONE;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                    if (div_cnt == div_q) begin
                        trig_n    = ~trig;
                        div_cnt_n = '0;
                    end else begin
                        div_cnt_n = div_cnt + DIV_ONE;
                    end
                end
            end
            S_OFF: begin
                if (cnt == '0) begin
                    state_n   = S_ON;
                    idx_n     = idx + BURST_ONE;
                    cnt_n     = on_ld;
                    div_cnt_n = '0;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                idx_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                trig_n  = 1'b0;
            end
        endcase

        if (bus.abort && (state == S_DELAY || state == S_ON || state == S_OFF)) begin
            state_n   = S_IDLE;
            cnt_n     = '0;
            div_cnt_n = '0;
            idx_n     = '0;
            trig_n    = 1'b0;
        end

        done_n = (state_n == S_DONE);
        busy_n = (state_n == S_DELAY) || (state_n == S_ON) || (state_n == S_OFF);
    end

    assign bus.activity_trig = trig;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.burst_idx     = idx;

endmodule
